// File: rtl/tod_clock_matrix.sv
// tod_clock_matrix: time-of-day counter (hh:mm:ss) on a single clock with a
// prescaled 1 Hz enable, a valid/ready time-load port, and a registered,
// row-multiplexed LED matrix driver showing {hours, minutes}.
module tod_clock_matrix #(
  parameter int DIV      = 100,
  parameter int DWELL    = 1,
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int MODE_12H = 0,
  parameter int COL_INV  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  output logic                 set_ready,
  input  logic [4:0]           set_hours,
  input  logic [5:0]           set_mins,
  output logic                 set_err,
  output logic [4:0]           hours,
  output logic [5:0]           minutes,
  output logic [5:0]           seconds,
  output logic                 sec_tick,
  output logic                 day_tick,
  output logic [ROWS+COLS-1:0] opins
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW   = $clog2(ROWS);
  localparam int NPIX = ROWS * COLS;

  localparam logic [4:0]      H_MIN  = (MODE_12H != 0) ? 5'd1  : 5'd0;
  localparam logic [4:0]      H_MAX  = (MODE_12H != 0) ? 5'd12 : 5'd23;
  localparam logic [4:0]      H_RST  = (MODE_12H != 0) ? 5'd12 : 5'd0;
  localparam logic [COLS-1:0] C_MASK = (COL_INV != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

  logic [PW-1:0]        r_presc;
  logic [5:0]           r_seconds;
  logic [5:0]           r_minutes;
  logic [4:0]           r_hours;
  logic                 r_sec_tick;
  logic                 r_day_tick;
  logic                 r_set_err;
  logic [DW-1:0]        r_dwell;
  logic [RW-1:0]        r_row;
  logic [ROWS+COLS-1:0] r_opins;

  logic                 w_wrap;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_hours_ok;
  logic                 w_row_change;
  logic [NPIX-1:0]      w_pix;
  logic [COLS-1:0]      w_cols;
  logic [ROWS-1:0]      w_rows;

  // Load handshake: a transfer happens on a rising edge where set_valid and
  // set_ready are both 1; set_hours/set_mins are only looked at on that edge.
  // The port is ready whenever reset is not asserted.
  assign set_ready = ~rst;
  assign w_accept  = set_valid & set_ready;

  // A load is legal when hours fit the selected 12/24 h range and minutes <= 59.
  assign w_hours_ok = (MODE_12H != 0) ? ((set_hours != 5'd0) && (set_hours <= 5'd12))
                                      : (set_hours <= 5'd23);
  assign w_legal    = w_hours_ok && (set_mins <= 6'd59);

  assign w_wrap       = (r_presc == PW'(DIV - 1));
  assign w_row_change = (r_dwell == DW'(DWELL - 1));

  // Timekeeping: prescaler, seconds/minutes/hours carry chain, and the load port.
  // A legal load overrides any tick due on the same edge, including a day wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_seconds  <= 6'd0;
      r_minutes  <= 6'd0;
      r_hours    <= H_RST;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_err  <= 1'b0;
      if (w_accept && w_legal) begin
        r_hours   <= set_hours;
        r_minutes <= set_mins;
        r_seconds <= 6'd0;
        r_presc   <= '0;
      end else begin
        if (w_accept) begin
          r_set_err <= 1'b1;
        end
        if (w_wrap) begin
          r_presc    <= '0;
          r_sec_tick <= 1'b1;
          if (r_seconds == 6'd59) begin
            r_seconds <= 6'd0;
            if (r_minutes == 6'd59) begin
              r_minutes <= 6'd0;
              if (r_hours == H_MAX) begin
                r_hours    <= H_MIN;
                r_day_tick <= 1'b1;
              end else begin
                r_hours <= r_hours + 5'd1;
              end
            end else begin
              r_minutes <= r_minutes + 6'd1;
            end
          end else begin
            r_seconds <= r_seconds + 6'd1;
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  // Pixel map: minutes in the low bits, hours above, zero-padded to the matrix size.
  always_comb begin
    w_pix        = '0;
    w_pix[10:0]  = {r_hours, r_minutes};
  end

  // Column slice and active-low one-hot row select for the row about to be driven.
  always_comb begin
    w_cols = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_row == RW'(r)) begin
        w_cols = w_pix[r*COLS +: COLS];
      end
    end
    w_rows = ~(ROWS'(1) << r_row);
  end

  // Scan: each row is held DWELL cycles; the outputs only change at a row change,
  // so a new time appears at the next row boundary and never mid-row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
      r_row   <= '0;
      r_opins <= '0;
    end else if (w_row_change) begin
      r_dwell <= '0;
      r_opins <= {w_rows, w_cols ^ C_MASK};
      r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign sec_tick = r_sec_tick;
  assign day_tick = r_day_tick;
  assign set_err  = r_set_err;
  assign opins    = r_opins;

endmodule

// File: tb/tb_tod_clock_matrix.sv
// Directed bench for tod_clock_matrix. Two instances share clock and reset:
// dut_a runs 24 h with normal columns, dut_b runs 12 h with inverted columns.
// Both use DIV=4, DWELL=3 and a 4x4 matrix.
module tb_tod_clock_matrix;

  logic       clk;
  logic       rst;

  logic       sva, svb;
  logic [4:0] sha, shb;
  logic [5:0] sma, smb;

  logic       rdy_a, rdy_b, err_a, err_b;
  logic [4:0] hr_a, hr_b;
  logic [5:0] mn_a, mn_b, sc_a, sc_b;
  logic       st_a, st_b, dt_a, dt_b;
  logic [7:0] op_a, op_b;

  int         n_vec;
  int         n_err;
  int         n_dt_a;
  int         n_dt_b;
  logic [3:0] prev_rows;
  logic       found;

  // Expected scan for 05:09 ({hours,minutes} = 00101_001001):
  // row0 pix[3:0]=1001, row1 pix[7:4]=0100, row2 pix[11:8]=0001, row3 0000.
  logic [7:0] exp_scan_a [4] = '{8'hE9, 8'hD4, 8'hB1, 8'h70};
  logic [7:0] exp_scan_b [4] = '{8'hE6, 8'hDB, 8'hBE, 8'h7F};

  tod_clock_matrix #(
    .DIV(4), .DWELL(3), .ROWS(4), .COLS(4), .MODE_12H(0), .COL_INV(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .set_valid(sva), .set_ready(rdy_a), .set_hours(sha), .set_mins(sma),
    .set_err(err_a), .hours(hr_a), .minutes(mn_a), .seconds(sc_a),
    .sec_tick(st_a), .day_tick(dt_a), .opins(op_a)
  );

  tod_clock_matrix #(
    .DIV(4), .DWELL(3), .ROWS(4), .COLS(4), .MODE_12H(1), .COL_INV(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .set_valid(svb), .set_ready(rdy_b), .set_hours(shb), .set_mins(smb),
    .set_err(err_b), .hours(hr_b), .minutes(mn_b), .seconds(sc_b),
    .sec_tick(st_b), .day_tick(dt_b), .opins(op_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; all driving and sampling happens 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a load on either or both ports for exactly one edge.
  task automatic load(input logic va, input logic [4:0] ha, input logic [5:0] ma,
                      input logic vb, input logic [4:0] hb, input logic [5:0] mb);
    sva = va; sha = ha; sma = ma;
    svb = vb; shb = hb; smb = mb;
    tick();
    sva = 1'b0;
    svb = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    sva = 1'b0; sha = 5'd0; sma = 6'd0;
    svb = 1'b0; shb = 5'd0; smb = 6'd0;

    // Reset state
    tick();
    tick();
    check("rst_hours_a", hr_a, 0);
    check("rst_min_a", mn_a, 0);
    check("rst_sec_a", sc_a, 0);
    check("rst_hours_b", hr_b, 12);
    check("rst_opins_a", op_a, 0);
    check("rst_opins_b", op_b, 0);
    check("rst_pulses_a", {st_a, dt_a, err_a}, 0);
    check("rst_ready_a", rdy_a, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy_a, 1);

    // Free run 16 edges: sec_tick every 4th, first row change 3 edges after release
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("sec_tick_a", st_a, ((k % 4) == 0));
      check("sec_tick_b", st_b, ((k % 4) == 0));
      if (k == 2)  check("opins_before_scan", op_a, 8'h00);
      if (k == 3)  begin check("scan_r0_a", op_a, 8'hE0); check("scan_r0_b", op_b, 8'hEF); end
      if (k == 6)  begin check("scan_r1_a", op_a, 8'hD0); check("scan_r1_b", op_b, 8'hDF); end
      if (k == 9)  begin check("scan_r2_a", op_a, 8'hB0); check("scan_r2_b", op_b, 8'hBC); end
      if (k == 12) begin check("scan_r3_a", op_a, 8'h70); check("scan_r3_b", op_b, 8'h7F); end
      if (k == 15) begin check("scan_wrap_a", op_a, 8'hE0); check("scan_wrap_b", op_b, 8'hEF); end
    end
    check("run16_sec_a", sc_a, 4);
    check("run16_hm_a", {hr_a, mn_a}, 0);
    check("run16_sec_b", sc_b, 4);
    check("run16_hours_b", hr_b, 12);

    // Display of 05:09 on both instances, from the first row-0 entry after the load
    load(1'b1, 5'd5, 6'd9, 1'b1, 5'd5, 6'd9);
    check("load_0509_a", {hr_a, mn_a}, {5'd5, 6'd9});
    check("load_0509_b", {hr_b, mn_b}, {5'd5, 6'd9});
    found = 1'b0;
    prev_rows = op_a[7:4];
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (op_a[7:4] == 4'hE && prev_rows != 4'hE) found = 1'b1;
      prev_rows = op_a[7:4];
    end
    check("row0_sync", found, 1);
    for (int i = 0; i < 12; i++) begin
      check("scan_0509_a", op_a, exp_scan_a[i/3]);
      check("scan_0509_b", op_b, exp_scan_b[i/3]);
      tick();
    end

    // Day rollover: a 23:59 -> 00:00, b 12:59 -> 01:00, after 60 s
    load(1'b1, 5'd23, 6'd59, 1'b1, 5'd12, 6'd59);
    check("load_2359_a", {hr_a, mn_a, sc_a}, {5'd23, 6'd59, 6'd0});
    check("load_1259_b", {hr_b, mn_b, sc_b}, {5'd12, 6'd59, 6'd0});
    n_dt_a = 0; n_dt_b = 0;
    for (int i = 0; i < 239; i++) begin
      tick();
      n_dt_a += int'(dt_a);
      n_dt_b += int'(dt_b);
    end
    check("pre_wrap_a", {hr_a, mn_a, sc_a}, {5'd23, 6'd59, 6'd59});
    check("pre_wrap_b", {hr_b, mn_b, sc_b}, {5'd12, 6'd59, 6'd59});
    check("early_day_tick_a", n_dt_a, 0);
    check("early_day_tick_b", n_dt_b, 0);
    tick();
    check("wrap_time_a", {hr_a, mn_a, sc_a}, 0);
    check("wrap_pulses_a", {st_a, dt_a}, 2'b11);
    check("wrap_time_b", {hr_b, mn_b, sc_b}, {5'd1, 6'd0, 6'd0});
    check("wrap_pulses_b", {st_b, dt_b}, 2'b11);
    tick();
    check("day_tick_len", {dt_a, dt_b}, 2'b00);

    // Load legality and tick discard
    load(1'b1, 5'd0, 6'd10, 1'b1, 5'd1, 6'd0);
    check("load_0010_a", {hr_a, mn_a, sc_a, err_a}, {5'd0, 6'd10, 6'd0, 1'b0});
    check("load_0100_b", {hr_b, mn_b, sc_b, err_b}, {5'd1, 6'd0, 6'd0, 1'b0});
    tick();
    load(1'b1, 5'd24, 6'd0, 1'b1, 5'd0, 6'd10);
    check("err_24h_a", err_a, 1);
    check("err_0h_b", err_b, 1);
    check("keep_time_a", {hr_a, mn_a}, {5'd0, 6'd10});
    check("keep_time_b", {hr_b, mn_b}, {5'd1, 6'd0});
    tick();
    check("err_len", {err_a, err_b}, 2'b00);
    // This edge is a prescaler wrap: the load must swallow the tick
    load(1'b1, 5'd10, 6'd30, 1'b1, 5'd12, 6'd0);
    check("load_on_wrap_a", {hr_a, mn_a, sc_a, st_a}, {5'd10, 6'd30, 6'd0, 1'b0});
    check("load_on_wrap_b", {hr_b, mn_b, sc_b, st_b}, {5'd12, 6'd0, 6'd0, 1'b0});
    load(1'b1, 5'd10, 6'd60, 1'b0, 5'd0, 6'd0);
    check("err_60m_a", err_a, 1);
    check("err_none_b", err_b, 0);
    check("keep_1030_a", {hr_a, mn_a, sc_a}, {5'd10, 6'd30, 6'd0});
    tick();
    check("no_handshake_ignored", {err_a, hr_a, mn_a}, {1'b0, 5'd10, 6'd30});

    // Load coinciding with 23:59:59 wrap wins, no day_tick
    load(1'b1, 5'd23, 6'd59, 1'b0, 5'd0, 6'd0);
    for (int i = 0; i < 239; i++) tick();
    load(1'b1, 5'd8, 6'd15, 1'b0, 5'd0, 6'd0);
    check("load_wins_time", {hr_a, mn_a, sc_a}, {5'd8, 6'd15, 6'd0});
    check("load_wins_pulses", {st_a, dt_a}, 2'b00);

    // Reset mid-scan with a load pending
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    load(1'b1, 5'd5, 6'd5, 1'b1, 5'd5, 6'd5);
    check("mid_rst_opins", {op_a, op_b}, 16'h0000);
    check("mid_rst_time_a", {hr_a, mn_a, sc_a}, 0);
    check("mid_rst_time_b", {hr_b, mn_b, sc_b}, {5'd12, 6'd0, 6'd0});
    check("mid_rst_pulses", {st_a, dt_a, err_a, st_b, dt_b, err_b}, 0);
    check("mid_rst_ready", {rdy_a, rdy_b}, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 3)  check("restart_blank", op_a, 8'h00);
      if (k == 3) begin check("restart_r0_a", op_a, 8'hE0); check("restart_r0_b", op_b, 8'hEF); end
      if (k == 4) check("restart_tick", {st_a, sc_a, hr_a}, {1'b1, 6'd1, 5'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
